// File: rtl/jt49_mdly.sv
// Multi-channel programmable sample delay line for the JT49 filter/echo path.
// One time-multiplexed RAM holds a circular buffer per channel; a small sequencer walks all channels per tick.
module jt49_mdly #(
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int CH    = 3,
    parameter int CHW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [CH*DW-1:0]     din,
    input  logic [DEPTH-1:0]     len,
    output logic [CH*DW-1:0]     dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 ovf
);

    localparam int              AW        = CHW + DEPTH;
    localparam int              WORDS     = CH * (2 ** DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);
    localparam logic [CHW-1:0]  LAST_CH   = CHW'(CH - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      clr_addr_q, clr_addr_d;
    logic [DEPTH-1:0]   wrpos_q, wrpos_d;
    logic [DEPTH-1:0]   len_q, len_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [CH*DW-1:0]   in_buf_q, in_buf_d;
    logic [CH*DW-1:0]   out_buf_q, out_buf_d;
    logic [CH*DW-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic [DW-1:0]      ram [WORDS];
    logic [DW-1:0]      ram_rdata;
    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [AW-1:0]      ram_raddr;
    logic [DW-1:0]      ram_wdata;
    logic [DEPTH-1:0]   rdpos;

    // rdpos never equals wrpos unless len_q is zero, and that case bypasses the RAM
    assign rdpos = wrpos_q - len_q;

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        wrpos_d      = wrpos_q;
        len_d        = len_q;
        ch_d         = ch_q;
        in_buf_d     = in_buf_q;
        out_buf_d    = out_buf_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;
        ovf_d        = ovf_q;
        ram_we       = 1'b0;
        ram_waddr    = {ch_q, wrpos_q};
        ram_raddr    = {ch_q, rdpos};
        ram_wdata    = in_buf_q[int'(ch_q)*DW +: DW];

        case (state_q)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (cen) begin
                    in_buf_d = din;
                    len_d    = len;
                    ch_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                ram_we = 1'b1;
                if (len_q == '0) begin
                    out_buf_d[int'(ch_q)*DW +: DW] = in_buf_q[int'(ch_q)*DW +: DW];
                end else begin
                    out_buf_d[int'(ch_q)*DW +: DW] = ram_rdata;
                end
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                dout_d       = out_buf_q;
                dout_valid_d = 1'b1;
                wrpos_d      = wrpos_q + 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        if (cen && (state_q == S_RD || state_q == S_WR || state_q == S_DONE)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= '0;
            wrpos_q      <= '0;
            len_q        <= '0;
            ch_q         <= '0;
            in_buf_q     <= '0;
            out_buf_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wrpos_q      <= wrpos_d;
            len_q        <= len_d;
            ch_q         <= ch_d;
            in_buf_q     <= in_buf_d;
            out_buf_q    <= out_buf_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    // RAM content is deliberately not reset; the CLEAR sweep initialises it
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_raddr];
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_jt49_mdly.sv
// Self-checking bench for jt49_mdly: table vectors, a sample-history model and a scoreboard of expected frames.
module tb_jt49_mdly;

    localparam int DW         = 8;
    localparam int DEPTH      = 4;
    localparam int CH         = 3;
    localparam int CHW        = 2;
    localparam int FW         = CH * DW;
    localparam int CLEAR_CLKS = CH * (2 ** DEPTH);
    localparam int LAT        = 2 * CH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cen;
    logic [FW-1:0]    din;
    logic [DEPTH-1:0] len;
    logic [FW-1:0]    dout;
    logic             dout_valid;
    logic             busy;
    logic             ovf;

    always #5 clk = ~clk;

    jt49_mdly #(.DW(DW), .DEPTH(DEPTH), .CH(CH), .CHW(CHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .din        (din),
        .len        (len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    typedef struct {
        logic [FW-1:0] exp;
        int            stamp;
    } sb_t;

    typedef struct {
        logic [FW-1:0]    din;
        logic [DEPTH-1:0] len;
        logic [FW-1:0]    exp;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    sb_t           sbq[$];
    logic [FW-1:0] hist[$];
    vec_t          vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Output for a new sample: the accepted sample len frames back, zero before that many were written
    function automatic logic [FW-1:0] modelOut(input logic [FW-1:0] d, input int l);
        int idx = hist.size() - l;
        if (l == 0) return d;
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected dout_valid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                checkOutput("dout", 32'(dout), 32'(e.exp));
                checkOutput("latency", 32'(cyc - e.stamp), 32'(LAT));
            end
        end
    end

    task automatic applyStimulus(input logic [FW-1:0] d, input logic [DEPTH-1:0] l, input int gap,
                                 input bit accept, input bit useTab, input logic [FW-1:0] texp);
        logic [FW-1:0] e;
        @(negedge clk);
        din = d;
        len = l;
        cen = 1'b1;
        @(posedge clk);
        #1;
        if (accept) begin
            e = useTab ? texp : modelOut(d, int'(l));
            hist.push_back(d);
            sbq.push_back('{exp: e, stamp: cyc});
            checkOutput("busy after accept", 32'(busy), 32'd1);
        end else begin
            checkOutput("ovf after drop", 32'(ovf), 32'd1);
        end
        @(negedge clk);
        cen = 1'b0;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic waitClear(input bit pulses, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            cen = pulses && (n % 10 == 3);
        end while (busy && n < 1000);
        cen = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        logic [FW-1:0] d;

        rst = 1'b1;
        cen = 1'b0;
        din = '0;
        len = '0;

        vecs[0] = '{din: 24'h211101, len: 4'd1, exp: 24'h000000};
        vecs[1] = '{din: 24'h221202, len: 4'd1, exp: 24'h211101};
        vecs[2] = '{din: 24'h231303, len: 4'd1, exp: 24'h221202};
        vecs[3] = '{din: 24'h241404, len: 4'd1, exp: 24'h231303};
        vecs[4] = '{din: 24'h251505, len: 4'd1, exp: 24'h241404};

        repeat (3) @(negedge clk);
        checkOutput("reset dout", 32'(dout), 32'd0);
        checkOutput("reset dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd1);
        checkOutput("reset ovf", 32'(ovf), 32'd0);

        rst = 1'b0;
        waitClear(1'b1, n);
        checkOutput("clear length", 32'(n), 32'(CLEAR_CLKS));
        checkOutput("ovf after clear", 32'(ovf), 32'd0);
        checkOutput("dout after clear", 32'(dout), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].din, vecs[i].len, 8, 1'b1, 1'b1, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            d = {8'(8'h80 + i), 8'(8'h40 + i), 8'(i)};
            applyStimulus(d, 4'd5, 8, 1'b1, 1'b0, '0);
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(FW'($urandom), 4'd0, 8, 1'b1, 1'b0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(FW'($urandom), 4'd3, 8, 1'b1, 1'b0, '0);
        end
        checkOutput("ovf before overrun", 32'(ovf), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(FW'($urandom), 4'd2, 4, (i % 2 == 0), 1'b0, '0);
        end
        applyStimulus(FW'($urandom), 4'd2, 8, 1'b1, 1'b0, '0);
        checkOutput("ovf sticky", 32'(ovf), 32'd1);
        repeat (10) @(negedge clk);

        // Reset lands while channel 1 is being written
        din = 24'h5a5a5a;
        len = 4'd2;
        cen = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cen = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midframe rst dout", 32'(dout), 32'd0);
        checkOutput("midframe rst valid", 32'(dout_valid), 32'd0);
        checkOutput("midframe rst ovf", 32'(ovf), 32'd0);
        checkOutput("midframe rst busy", 32'(busy), 32'd1);
        hist.delete();
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitClear(1'b0, n);
        checkOutput("clear length rerun", 32'(n), 32'(CLEAR_CLKS));

        for (int i = 0; i < 5; i++) begin
            applyStimulus(FW'($urandom) | 24'h010101, 4'd2, 8, 1'b1, 1'b0, '0);
        end

        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("scoreboard drain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
